// File: rtl/mdu_pkg.sv
// Shared MDU definitions: opcode encoding, FSM states and opcode class helpers.
package mdu_pkg;

    typedef enum logic [3:0] {
        MULT  = 4'd0,
        MULTU = 4'd1,
        DIV   = 4'd2,
        DIVU  = 4'd3,
        MADD  = 4'd4,
        MADDU = 4'd5,
        MSUB  = 4'd6,
        MSUBU = 4'd7,
        MTHI  = 4'd8,
        MTLO  = 4'd9
    } mdu_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic is_div(input mdu_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_acc(input mdu_op_t op);
        return (op == MADD) || (op == MADDU) || (op == MSUB) || (op == MSUBU);
    endfunction

    // Ops that occupy the unit for a latency window and commit through the FSM.
    function automatic logic is_arith(input mdu_op_t op);
        return (op == MULT) || (op == MULTU) || is_div(op) || is_acc(op);
    endfunction

endpackage

// File: rtl/mdu_ext_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface mdu_ext_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    mdu_op_t          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_ext_calc.sv
// Combinational MDU datapath: products, accumulate and divide with the
// divide-by-zero and MIN_INT/-1 results defined rather than trapping.
module mdu_ext_calc
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  mdu_op_t            op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [2*WIDTH-1:0] acc_i,
    output logic [2*WIDTH-1:0] res_o
);

    logic signed [2*WIDTH-1:0] a_sx;
    logic signed [2*WIDTH-1:0] b_sx;
    logic [2*WIDTH-1:0]        prod_s;
    logic [2*WIDTH-1:0]        prod_u;
    logic [WIDTH-1:0]          min_int;
    logic                      div_zero;
    logic                      div_ovf;
    logic [WIDTH-1:0]          mag_a;
    logic [WIDTH-1:0]          mag_b;
    logic [WIDTH-1:0]          den_s;
    logic [WIDTH-1:0]          den_u;
    logic [WIDTH-1:0]          uq;
    logic [WIDTH-1:0]          ur;
    logic [WIDTH-1:0]          q_s;
    logic [WIDTH-1:0]          r_s;
    logic [WIDTH-1:0]          q_u;
    logic [WIDTH-1:0]          r_u;

    assign a_sx   = {{WIDTH{a_i[WIDTH-1]}}, a_i};
    assign b_sx   = {{WIDTH{b_i[WIDTH-1]}}, b_i};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

    assign min_int  = {1'b1, {(WIDTH-1){1'b0}}};
    assign div_zero = (b_i == '0);
    assign div_ovf  = (a_i == min_int) && (b_i == '1);

    // Signed divide is done on magnitudes so no native signed divide ever
    // sees MIN_INT/-1; the divisor is forced to 1 when zero to keep it benign.
    assign mag_a = a_i[WIDTH-1] ? ('0 - a_i) : a_i;
    assign mag_b = b_i[WIDTH-1] ? ('0 - b_i) : b_i;
    assign den_s = div_zero ? WIDTH'(1) : mag_b;
    assign den_u = div_zero ? WIDTH'(1) : b_i;
    assign uq    = mag_a / den_s;
    assign ur    = mag_a % den_s;
    assign q_s   = (a_i[WIDTH-1] ^ b_i[WIDTH-1]) ? ('0 - uq) : uq;
    assign r_s   = a_i[WIDTH-1] ? ('0 - ur) : ur;
    assign q_u   = a_i / den_u;
    assign r_u   = a_i % den_u;

    always_comb begin
        res_o = acc_i;
        case (op_i)
            MULT:  res_o = prod_s;
            MULTU: res_o = prod_u;
            MADD:  res_o = acc_i + prod_s;
            MADDU: res_o = acc_i + prod_u;
            MSUB:  res_o = acc_i - prod_s;
            MSUBU: res_o = acc_i - prod_u;
            DIV: begin
                if (div_zero)     res_o = {a_i, {WIDTH{1'b1}}};
                else if (div_ovf) res_o = {{WIDTH{1'b0}}, min_int};
                else              res_o = {r_s, q_s};
            end
            DIVU: begin
                if (div_zero) res_o = {a_i, {WIDTH{1'b1}}};
                else          res_o = {r_u, q_u};
            end
            default: res_o = acc_i;
        endcase
    end

endmodule

// File: rtl/mdu_ext.sv
// Multiply/divide unit with HI/LO for the EX stage: latency-counted FSM,
// flush abort, one-cycle done pulse; results stay hidden until commit.
//
//   state | meaning
//   IDLE  | accepts start; MTHI/MTLO write immediately, arith ops latch and go RUN
//   RUN   | down-counter running; commits {hi,lo} at terminal count 1, flush aborts
module mdu_ext
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input logic       clk,
    input logic       reset,
    mdu_ext_if.slave  mdu_if
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    mdu_op_t            op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] res;

    mdu_ext_calc #(.WIDTH(WIDTH)) u_calc (
        .op_i  (op_q),
        .a_i   (a_q),
        .b_i   (b_q),
        .acc_i (acc_q),
        .res_o (res)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= MULT;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mdu_if.start && !mdu_if.flush) begin
                    if (is_arith(mdu_if.op)) begin
                        state_d = RUN;
                        op_d    = mdu_if.op;
                        a_d     = mdu_if.a;
                        b_d     = mdu_if.b;
                        acc_d   = {hi_q, lo_q};
                        cnt_d   = is_div(mdu_if.op) ? CW'(DIV_LAT) : CW'(MUL_LAT);
                    end else if (mdu_if.op == MTHI) begin
                        hi_d = mdu_if.a;
                    end else if (mdu_if.op == MTLO) begin
                        lo_d = mdu_if.a;
                    end
                end
            end
            RUN: begin
                // Flush has priority even on the terminal-count cycle.
                if (mdu_if.flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(1)) begin
                    {hi_d, lo_d} = res;
                    done_d       = 1'b1;
                    state_d      = IDLE;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mdu_if.busy = (state_q == RUN);
    assign mdu_if.done = done_q;
    assign mdu_if.hi   = hi_q;
    assign mdu_if.lo   = lo_q;

endmodule

// File: tb/tb_mdu_ext.sv
// Directed bench for mdu_ext: vector table for arithmetic results and latency,
// plus hand sequences for flush, reset, stalled starts and a narrow instance.
module tb_mdu_ext;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mdu_ext_if #(.WIDTH(32)) bus ();
    mdu_ext_if #(.WIDTH(16)) bus16 ();

    mdu_ext #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .mdu_if (bus)
    );

    mdu_ext #(.WIDTH(16), .MUL_LAT(1), .DIV_LAT(3)) dut16 (
        .clk    (clk),
        .reset  (reset),
        .mdu_if (bus16)
    );

    typedef struct {
        string       name;
        mdu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic mt(input mdu_op_t o, input logic [31:0] v);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.a = v; bus.b = '0;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Issues one op and watches max_cyc cycles; k=1 is the first cycle after the issue edge.
    task automatic issue_watch(input mdu_op_t o, input logic [31:0] xa, input logic [31:0] xb,
                               input logic [31:0] old_hi, input logic [31:0] old_lo,
                               input int max_cyc, output int nbusy, output int ndone,
                               output int done_at, output int nvis);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.a = xa; bus.b = xb;
        @(negedge clk);
        bus.start = 1'b0;
        nbusy = 0; ndone = 0; done_at = -1; nvis = 0;
        for (int k = 1; k <= max_cyc; k++) begin
            if (bus.busy) begin
                nbusy++;
                if (bus.hi !== old_hi || bus.lo !== old_lo) nvis++;
            end
            if (bus.done) begin
                ndone++;
                done_at = k;
            end
            @(negedge clk);
        end
    endtask

    task automatic issue16(input mdu_op_t o, input logic [15:0] xa, input logic [15:0] xb,
                           output int nbusy, output int done_at);
        @(negedge clk);
        bus16.start = 1'b1; bus16.op = o; bus16.a = xa; bus16.b = xb;
        @(negedge clk);
        bus16.start = 1'b0;
        nbusy = 0; done_at = -1;
        for (int k = 1; k <= 6; k++) begin
            if (bus16.busy) nbusy++;
            if (bus16.done) done_at = k;
            @(negedge clk);
        end
    endtask

    // Aborts a MULT 4*4 with flush raised in busy cycle cyc.
    task automatic flush_at(input int cyc, input string nm);
        int nd;
        mt(MTHI, 32'hAAAA0000);
        mt(MTLO, 32'h0000BBBB);
        @(negedge clk);
        bus.start = 1'b1; bus.op = MULT; bus.a = 32'd4; bus.b = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k < cyc; k++) @(negedge clk);
        chk({nm, "_busy_before"}, 64'(bus.busy), 64'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk({nm, "_busy_after"}, 64'(bus.busy), 64'd0);
        nd = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.done) nd++;
            @(negedge clk);
        end
        chk({nm, "_no_done"}, 64'(nd), 64'd0);
        chk({nm, "_hilo"}, {bus.hi, bus.lo}, 64'hAAAA0000_0000BBBB);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nbusy, ndone, done_at, nvis, nd;
        bit seen;

        vecs[0]  = '{"mult_neg",   MULT,  32'hFFFFFFFD, 32'd7,        32'h0, 32'h0,  32'hFFFFFFFF, 32'hFFFFFFEB, 5};
        vecs[1]  = '{"div_neg",    DIV,   32'hFFFFFFF9, 32'd2,        32'h0, 32'h0,  32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[2]  = '{"divu_zero",  DIVU,  32'd7,        32'd0,        32'h0, 32'h0,  32'h00000007, 32'hFFFFFFFF, 10};
        vecs[3]  = '{"maddu",      MADDU, 32'hFFFFFFFF, 32'd2,        32'h0, 32'd5,  32'h00000002, 32'h00000003, 5};
        vecs[4]  = '{"div_ovf",    DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0,  32'h00000000, 32'h80000000, 10};
        vecs[5]  = '{"multu_max",  MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0,  32'hFFFFFFFE, 32'h00000001, 5};
        vecs[6]  = '{"msub",       MSUB,  32'd3,        32'd4,        32'h0, 32'd10, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[7]  = '{"madd_neg",   MADD,  32'hFFFFFFFF, 32'd1,        32'h1, 32'h0,  32'h00000000, 32'hFFFFFFFF, 5};
        vecs[8]  = '{"msubu_wrap", MSUBU, 32'd1,        32'd1,        32'h0, 32'h0,  32'hFFFFFFFF, 32'hFFFFFFFF, 5};
        vecs[9]  = '{"divu",       DIVU,  32'hFFFFFFFF, 32'h10,       32'h0, 32'h0,  32'h0000000F, 32'h0FFFFFFF, 10};
        vecs[10] = '{"div_negdiv", DIV,   32'd7,        32'hFFFFFFFE, 32'h0, 32'h0,  32'h00000001, 32'hFFFFFFFD, 10};
        vecs[11] = '{"div_zero",   DIV,   32'hFFFFFFFB, 32'd0,        32'h0, 32'h0,  32'hFFFFFFFB, 32'hFFFFFFFF, 10};

        bus.start = 1'b0; bus.op = MULT; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
        bus16.start = 1'b0; bus16.op = MULT; bus16.a = '0; bus16.b = '0; bus16.flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        chk("reset_hilo", {bus.hi, bus.lo}, 64'h0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);

        mt(MTHI, 32'h00001234);
        chk("mthi_hi", 64'(bus.hi), 64'h1234);
        chk("mthi_busy", 64'(bus.busy), 64'd0);
        chk("mthi_done", 64'(bus.done), 64'd0);

        for (int i = 0; i < 12; i++) begin
            mt(MTHI, vecs[i].pre_hi);
            mt(MTLO, vecs[i].pre_lo);
            issue_watch(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].pre_hi, vecs[i].pre_lo,
                        vecs[i].lat + 4, nbusy, ndone, done_at, nvis);
            chk({vecs[i].name, "_hilo"}, {bus.hi, bus.lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
            chk({vecs[i].name, "_busy_cycles"}, 64'(nbusy), 64'(vecs[i].lat));
            chk({vecs[i].name, "_done_count"}, 64'(ndone), 64'd1);
            chk({vecs[i].name, "_done_cycle"}, 64'(done_at), 64'(vecs[i].lat + 1));
            chk({vecs[i].name, "_hidden"}, 64'(nvis), 64'd0);
        end

        flush_at(3, "flush_c3");
        flush_at(5, "flush_tc");

        // start together with flush in IDLE issues nothing
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = MULT; bus.a = 32'd2; bus.b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        chk("startflush_busy", 64'(bus.busy), 64'd0);
        nd = 0;
        for (int k = 0; k < 7; k++) begin
            if (bus.done) nd++;
            @(negedge clk);
        end
        chk("startflush_no_done", 64'(nd), 64'd0);
        chk("startflush_hilo", {bus.hi, bus.lo}, 64'hAAAA0000_0000BBBB);

        // MTLO together with flush is also suppressed
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = MTLO; bus.a = 32'h55;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        chk("mtlo_flush_lo", 64'(bus.lo), 64'h0000BBBB);

        // unknown opcode is a no-op
        @(negedge clk);
        bus.start = 1'b1; bus.op = mdu_op_t'(4'hC); bus.a = 32'hFFFF; bus.b = 32'h1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("unknown_busy", 64'(bus.busy), 64'd0);
        nd = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.done) nd++;
            @(negedge clk);
        end
        chk("unknown_no_done", 64'(nd), 64'd0);
        chk("unknown_hilo", {bus.hi, bus.lo}, 64'hAAAA0000_0000BBBB);

        // MTHI while busy is dropped
        mt(MTHI, 32'h1);
        mt(MTLO, 32'h0);
        @(negedge clk);
        bus.start = 1'b1; bus.op = MULTU; bus.a = 32'd2; bus.b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = MTHI; bus.a = 32'hDEAD;
        @(negedge clk);
        bus.start = 1'b0;
        chk("mthi_busy_hi", 64'(bus.hi), 64'h1);
        chk("mthi_busy_still", 64'(bus.busy), 64'd1);
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            if (bus.done) seen = 1'b1;
            else @(negedge clk);
        end
        chk("mthi_busy_done", 64'(seen), 64'd1);
        chk("mthi_busy_result", {bus.hi, bus.lo}, 64'h00000000_00000006);
        repeat (3) @(negedge clk);
        chk("mthi_busy_final", {bus.hi, bus.lo}, 64'h00000000_00000006);

        // reset in busy cycle 4 of DIV
        mt(MTHI, 32'h77);
        mt(MTLO, 32'h88);
        @(negedge clk);
        bus.start = 1'b1; bus.op = DIV; bus.a = 32'd100; bus.b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_busy_before", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_hilo", {bus.hi, bus.lo}, 64'h0);
        chk("rst_mid_busy", 64'(bus.busy), 64'd0);
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.done) nd++;
            @(negedge clk);
        end
        chk("rst_mid_no_done", 64'(nd), 64'd0);
        chk("rst_mid_hilo_after", {bus.hi, bus.lo}, 64'h0);

        // narrow instance with single-cycle multiply
        issue16(MULT, 16'hFFFD, 16'd7, nbusy, done_at);
        chk("w16_mult_busy", 64'(nbusy), 64'd1);
        chk("w16_mult_done_cycle", 64'(done_at), 64'd2);
        chk("w16_mult_hilo", {32'h0, bus16.hi, bus16.lo}, 64'hFFFFFFEB);
        issue16(DIV, 16'hFFF9, 16'd2, nbusy, done_at);
        chk("w16_div_busy", 64'(nbusy), 64'd3);
        chk("w16_div_done_cycle", 64'(done_at), 64'd4);
        chk("w16_div_hilo", {32'h0, bus16.hi, bus16.lo}, 64'hFFFFFFFD);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
